// File: rtl/mem_port_arbiter.sv
// Data-cache port arbiter: each cycle picks the load stream or the committed-store drain
// and registers the winner onto the MEM-stage request bus.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        mem_miss_halt,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_tag,
  input  logic [5:0]  ld_regmap,
  output logic        ld_grant,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [31:0] st_tag,
  input  logic        st_urgent,
  output logic        st_grant,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_tag,
  output logic [5:0]  mem_regmap,
  output logic [1:0]  arb_state
);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StMissWait  = 2'd1,
    StFlushDrop = 2'd2
  } state_e;

  localparam logic [3:0] LoseLimit = 4'(STARVE_LIMIT);
  localparam logic [3:0] LoseMax   = 4'hF;

  state_e      r_state;
  state_e      w_state_next;
  logic [3:0]  r_ld_lose;
  logic [3:0]  r_st_lose;
  logic [3:0]  w_ld_lose_next;
  logic [3:0]  w_st_lose_next;
  logic        r_rr_last;
  logic        w_rr_last_next;

  logic        r_mem_valid;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_mem_tag;
  logic [5:0]  r_mem_regmap;

  logic        w_port_open;
  logic        w_ld_elig;
  logic        w_st_elig;
  logic        w_hazard;
  logic        w_pick_store;

  // Winner selection; w_pick_store only matters when both sides are eligible.
  always_comb begin
    w_port_open = RESET && !STALL && !mem_miss_halt && (r_state == StIdle);
    w_ld_elig   = w_port_open && ld_req && !FLUSH;
    w_st_elig   = w_port_open && st_req;
    w_hazard    = (ld_addr[31:2] == st_addr[31:2]);

    w_pick_store = 1'b0;
    if (w_hazard) begin
      w_pick_store = 1'b1;
    end else if (r_ld_lose == LoseLimit) begin
      w_pick_store = 1'b0;
    end else if (r_st_lose == LoseLimit) begin
      w_pick_store = 1'b1;
    end else if (st_urgent) begin
      w_pick_store = 1'b1;
    end else begin
      w_pick_store = !r_rr_last;
    end

    ld_grant = w_ld_elig && !(w_st_elig && w_pick_store);
    st_grant = w_st_elig && !(w_ld_elig && !w_pick_store);
  end

  // Lose counters and round-robin pointer; grants are already zero under STALL.
  always_comb begin
    w_ld_lose_next = r_ld_lose;
    w_st_lose_next = r_st_lose;
    w_rr_last_next = r_rr_last;

    if (ld_grant) begin
      w_ld_lose_next = 4'd0;
      if (st_req && (r_st_lose != LoseMax)) begin
        w_st_lose_next = r_st_lose + 4'd1;
      end
    end
    if (st_grant) begin
      w_st_lose_next = 4'd0;
      if (ld_req && (r_ld_lose != LoseMax)) begin
        w_ld_lose_next = r_ld_lose + 4'd1;
      end
    end
    if (ld_grant || st_grant) begin
      w_rr_last_next = st_grant;
    end
    if (FLUSH && !STALL) begin
      w_ld_lose_next = 4'd0;
    end
  end

  // FLUSH beats a simultaneous miss; FLUSH_DROP always lasts exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!STALL) begin
          if (FLUSH) begin
            w_state_next = StFlushDrop;
          end else if (mem_miss_halt) begin
            w_state_next = StMissWait;
          end
        end
      end
      StMissWait: begin
        if (!STALL && !mem_miss_halt) begin
          w_state_next = StIdle;
        end
      end
      StFlushDrop: w_state_next = StIdle;
      default:     w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state   <= StIdle;
      r_ld_lose <= 4'd0;
      r_st_lose <= 4'd0;
      r_rr_last <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_ld_lose <= w_ld_lose_next;
      r_st_lose <= w_st_lose_next;
      r_rr_last <= w_rr_last_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_mem_valid  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_tag    <= 32'd0;
      r_mem_regmap <= 6'd0;
    end else begin
      r_mem_valid  <= ld_grant || st_grant;
      r_mem_we     <= st_grant;
      r_mem_addr   <= st_grant ? st_addr : (ld_grant ? ld_addr : 32'd0);
      r_mem_wdata  <= st_grant ? st_data : 32'd0;
      r_mem_tag    <= st_grant ? st_tag : (ld_grant ? ld_tag : 32'd0);
      r_mem_regmap <= ld_grant ? ld_regmap : 6'd0;
    end
  end

  // A registered load is speculative: FLUSH kills it in the cycle it is presented.
  assign mem_valid  = r_mem_valid && !(FLUSH && !r_mem_we);
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_tag    = r_mem_tag;
  assign mem_regmap = r_mem_regmap;
  assign arb_state  = r_state;

endmodule
